// File: rtl/alarm_stage_sequencer.sv
// alarm_stage_sequencer: timed multi-stage game flow for the disarm-alarm design.
// Runs NUM_STAGES answer stages with a per-second countdown and a timed penalty
// after each miss. Cumulative misses reaching MAX_STRIKES give a sticky lockout.
// Problems are pulled from the generator with a valid/take handshake.
module alarm_stage_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int ANS_W       = 8,
  parameter int CLK_HZ      = 50_000_000,
  parameter int INIT_SEC    = 1,
  parameter int STAGE_SEC   = 60,
  parameter int PENALTY_SEC = 3,
  parameter int MAX_STRIKES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             submit,
  input  logic [ANS_W-1:0] answer_in,
  input  logic             prob_valid,
  input  logic [ANS_W-1:0] prob_answer,
  output logic             prob_take,
  output logic [2:0]       state,
  output logic [3:0]       stage,
  output logic [7:0]       secs_left,
  output logic [3:0]       strikes,
  output logic             ev_correct,
  output logic             ev_wrong,
  output logic             ev_timeout
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH   = 3'd1,
    S_STAGE   = 3'd2,
    S_PENALTY = 3'd3,
    S_WIN     = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t             state_q;
  logic [3:0]         stage_q;
  logic [7:0]         secs_q;
  logic [3:0]         strikes_q;
  logic [PRESC_W-1:0] presc_q;
  logic [ANS_W-1:0]   ans_q;
  logic               submit_q;
  logic               ev_correct_q;
  logic               ev_wrong_q;
  logic               ev_timeout_q;

  logic       timed;
  logic       tick;
  logic       expiry;
  logic       sub_edge;
  logic       ans_match;
  logic [3:0] strikes_inc;
  logic       lockout_hit;

  // Miss counter saturates rather than wrapping so lockout can never be undone.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  assign timed       = (state_q == S_INIT) || (state_q == S_STAGE) || (state_q == S_PENALTY);
  assign tick        = timed && (presc_q == PRESC_MAX);
  assign expiry      = tick && (secs_q == 8'd1);
  assign sub_edge    = submit & ~submit_q;
  assign ans_match   = (answer_in == ans_q);
  assign strikes_inc = sat_inc4(strikes_q);
  assign lockout_hit = (strikes_inc >= 4'(MAX_STRIKES));

  assign prob_take  = !rst && (state_q == S_FETCH) && prob_valid;
  assign state      = state_q;
  assign stage      = stage_q;
  assign secs_left  = secs_q;
  assign strikes    = strikes_q;
  assign ev_correct = ev_correct_q;
  assign ev_wrong   = ev_wrong_q;
  assign ev_timeout = ev_timeout_q;

  // Game-flow FSM: state, countdown, prescaler, strikes, latched answer and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      stage_q      <= 4'd1;
      secs_q       <= 8'(INIT_SEC);
      strikes_q    <= 4'd0;
      presc_q      <= '0;
      ans_q        <= '0;
      submit_q     <= 1'b0;
      ev_correct_q <= 1'b0;
      ev_wrong_q   <= 1'b0;
      ev_timeout_q <= 1'b0;
    end else begin
      submit_q     <= submit;
      ev_correct_q <= 1'b0;
      ev_wrong_q   <= 1'b0;
      ev_timeout_q <= 1'b0;

      // Free-running second prescaler; transitions below override it to restart at 0.
      if (timed) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
      end else begin
        presc_q <= '0;
      end
      if (tick && !expiry) begin
        secs_q <= secs_q - 8'd1;
      end

      unique case (state_q)
        S_INIT: begin
          if (expiry) begin
            state_q <= S_FETCH;
            secs_q  <= 8'd0;
            presc_q <= '0;
          end
        end

        S_FETCH: begin
          secs_q <= 8'd0;
          if (prob_valid) begin
            ans_q   <= prob_answer;
            state_q <= S_STAGE;
            secs_q  <= 8'(STAGE_SEC);
            presc_q <= '0;
          end
        end

        S_STAGE: begin
          if (sub_edge && ans_match) begin
            ev_correct_q <= 1'b1;
            secs_q       <= 8'd0;
            presc_q      <= '0;
            if (stage_q == 4'(NUM_STAGES)) begin
              state_q <= S_WIN;
            end else begin
              stage_q <= stage_q + 4'd1;
              state_q <= S_FETCH;
            end
          end else if (sub_edge || expiry) begin
            // A submit edge coinciding with expiry is judged as a submit, not a timeout.
            ev_wrong_q   <= sub_edge;
            ev_timeout_q <= !sub_edge;
            strikes_q    <= strikes_inc;
            presc_q      <= '0;
            if (lockout_hit) begin
              state_q <= S_LOCKOUT;
              secs_q  <= 8'd0;
            end else begin
              state_q <= S_PENALTY;
              secs_q  <= 8'(PENALTY_SEC);
            end
          end
        end

        S_PENALTY: begin
          if (expiry) begin
            state_q <= S_FETCH;
            secs_q  <= 8'd0;
            presc_q <= '0;
          end
        end

        S_WIN, S_LOCKOUT: begin
          secs_q <= 8'd0;
        end

        default: begin
          state_q <= S_LOCKOUT;
          secs_q  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_stage_sequencer.sv
// Randomized bench for alarm_stage_sequencer, checked every cycle against a
// behavioural model that tracks elapsed cycles per state rather than a
// prescaler/second counter pair.
module tb_alarm_stage_sequencer;

  localparam int CLK_HZ      = 10;
  localparam int INIT_SEC    = 1;
  localparam int STAGE_SEC   = 4;
  localparam int PENALTY_SEC = 2;
  localparam int NUM_STAGES  = 2;
  localparam int MAX_STRIKES = 2;
  localparam int ANS_W       = 8;

  localparam int M_INIT = 0, M_FETCH = 1, M_STAGE = 2, M_PENALTY = 3, M_WIN = 4, M_LOCK = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             submit;
  logic [ANS_W-1:0] answer_in;
  logic             prob_valid;
  logic [ANS_W-1:0] prob_answer;
  logic             prob_take;
  logic [2:0]       state;
  logic [3:0]       stage;
  logic [7:0]       secs_left;
  logic [3:0]       strikes;
  logic             ev_correct;
  logic             ev_wrong;
  logic             ev_timeout;

  always #5 clk = ~clk;

  alarm_stage_sequencer #(
    .NUM_STAGES (NUM_STAGES),
    .ANS_W      (ANS_W),
    .CLK_HZ     (CLK_HZ),
    .INIT_SEC   (INIT_SEC),
    .STAGE_SEC  (STAGE_SEC),
    .PENALTY_SEC(PENALTY_SEC),
    .MAX_STRIKES(MAX_STRIKES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .submit     (submit),
    .answer_in  (answer_in),
    .prob_valid (prob_valid),
    .prob_answer(prob_answer),
    .prob_take  (prob_take),
    .state      (state),
    .stage      (stage),
    .secs_left  (secs_left),
    .strikes    (strikes),
    .ev_correct (ev_correct),
    .ev_wrong   (ev_wrong),
    .ev_timeout (ev_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int m_mode, m_stage, m_strikes, m_elapsed, m_total, m_ans;
  bit m_subq, m_evc, m_evw, m_evt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic m_enter(input int mode, input int total);
    m_mode    = mode;
    m_total   = total;
    m_elapsed = 0;
  endtask

  task automatic m_miss();
    m_strikes = (m_strikes >= 15) ? 15 : m_strikes + 1;
    if (m_strikes >= MAX_STRIKES) m_enter(M_LOCK, 0);
    else                          m_enter(M_PENALTY, PENALTY_SEC);
  endtask

  function automatic int m_secs();
    if (m_mode == M_INIT || m_mode == M_STAGE || m_mode == M_PENALTY)
      return m_total - m_elapsed / CLK_HZ;
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit sb, input int ai, input bit pv, input int pa);
    bit edge_s, expired;
    if (r) begin
      m_enter(M_INIT, INIT_SEC);
      m_stage = 1; m_strikes = 0; m_ans = 0; m_subq = 0;
      m_evc = 0; m_evw = 0; m_evt = 0;
      return;
    end
    edge_s  = sb && !m_subq;
    m_subq  = sb;
    m_evc = 0; m_evw = 0; m_evt = 0;
    expired = (m_elapsed == m_total * CLK_HZ - 1);
    case (m_mode)
      M_INIT:    if (expired) m_enter(M_FETCH, 0); else m_elapsed++;
      M_FETCH:   if (pv) begin m_ans = pa; m_enter(M_STAGE, STAGE_SEC); end
      M_STAGE: begin
        if (edge_s && ai == m_ans) begin
          m_evc = 1;
          if (m_stage == NUM_STAGES) m_enter(M_WIN, 0);
          else begin m_stage++; m_enter(M_FETCH, 0); end
        end else if (edge_s) begin
          m_evw = 1; m_miss();
        end else if (expired) begin
          m_evt = 1; m_miss();
        end else m_elapsed++;
      end
      M_PENALTY: if (expired) m_enter(M_FETCH, 0); else m_elapsed++;
      default: ;
    endcase
  endtask

  task automatic run_cycle(input bit r, input bit sb, input int ai, input bit pv, input int pa);
    @(negedge clk);
    rst = r; submit = sb; answer_in = 8'(ai); prob_valid = pv; prob_answer = 8'(pa);
    #1;
    check_eq("prob_take", {31'd0, prob_take}, {31'd0, (!r && m_mode == M_FETCH && pv)});
    @(posedge clk);
    model_step(r, sb, ai, pv, pa);
    cyc++;
    #1;
    check_eq("state",      {29'd0, state},      m_mode);
    check_eq("stage",      {28'd0, stage},      m_stage);
    check_eq("secs_left",  {24'd0, secs_left},  m_secs());
    check_eq("strikes",    {28'd0, strikes},    m_strikes);
    check_eq("ev_correct", {31'd0, ev_correct}, {31'd0, m_evc});
    check_eq("ev_wrong",   {31'd0, ev_wrong},   {31'd0, m_evw});
    check_eq("ev_timeout", {31'd0, ev_timeout}, {31'd0, m_evt});
  endtask

  initial begin
    bit sb, pv, r;
    int ai, pa, flip_rate, pv_rate;
    rst = 1'b1; submit = 1'b0; answer_in = '0; prob_valid = 1'b0; prob_answer = '0;
    m_enter(M_INIT, INIT_SEC);
    m_stage = 1; m_strikes = 0; m_ans = 0; m_subq = 0; m_evc = 0; m_evw = 0; m_evt = 0;
    sb = 0; pa = 8'h2A;
    for (int ep = 0; ep < 40 && n_fail < 200; ep++) begin
      case (ep % 4)
        0: flip_rate = 2;
        1: flip_rate = 8;
        2: flip_rate = 25;
        default: flip_rate = 5;
      endcase
      case (ep % 5)
        0, 1: pv_rate = 95;
        2:    pv_rate = 50;
        3:    pv_rate = 3;
        default: pv_rate = 80;
      endcase
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        run_cycle(1'b1, sb, 0, 1'b1, pa);
      for (int c = 0; c < 400 && n_fail < 200; c++) begin
        r = ($urandom_range(0, 499) == 0);
        if ($urandom_range(0, 99) < flip_rate) sb = !sb;
        pv = ($urandom_range(0, 99) < pv_rate);
        case ($urandom_range(0, 2))
          0: pa = 8'h2A;
          1: pa = 8'h11;
          default: pa = int'($urandom_range(0, 255));
        endcase
        ai = ($urandom_range(0, 9) < 6) ? m_ans : int'($urandom_range(0, 255));
        // Steer some submits onto the exact expiry cycle of a stage.
        if (ep % 3 == 0 && m_mode == M_STAGE) begin
          if (m_elapsed == STAGE_SEC * CLK_HZ - 2) sb = 0;
          if (m_elapsed == STAGE_SEC * CLK_HZ - 1) begin
            sb = 1;
            ai = ($urandom_range(0, 1) == 1) ? m_ans : (m_ans ^ 1);
          end
        end
        run_cycle(r, sb, ai, pv, pa);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
